// File: rtl/accum_pkg.sv
// Shared types and widths for the sample accumulator and its adder.
package accum_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;
endpackage

// File: rtl/adder_8bit.sv
// Plain 8-bit ripple-carry adder; the carry chain is the accumulator's critical path.
module adder_8bit
  import accum_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out
);

  logic [DATA_WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[DATA_WIDTH];
  end

endmodule

// File: rtl/sample_accumulator_8bit.sv
// Sums NUM_SAMPLES unsigned 8-bit samples through one adder_8bit and holds the
// wrapped sum plus a sticky carry flag on a valid/ready output until taken.
module sample_accumulator_8bit
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_overflow,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SAMPLES - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_co;
  logic                  accept;

  adder_8bit u_adder (
    .a         (acc_q),
    .b         (in_data),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  // DONE blocks input, so acceptance never depends on out_ready
  assign accept = in_valid && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d   = add_sum;
            ovf_d   = ovf_q | add_co;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = (cnt_q == LAST_CNT) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q != DONE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_sample_accumulator_8bit.sv
// Scoreboard bench: accepted samples are summed with plain integer arithmetic and
// the expected result is queued; a negedge monitor checks handshakes and outputs.
module tb_sample_accumulator_8bit;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic       out_ready;
  logic       busy;

  sample_accumulator_8bit #(.NUM_SAMPLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_results = 0;

  // Reference model state
  int   samples[$];
  int   exp_q[$];     // bit 8 = overflow, bits 7:0 = sum
  bit   pending = 0;
  bit   just_cleared = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard: inputs are stable at negedge, outputs reflect the last edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", int'(out_valid), int'(pending));
      chk("in_ready", int'(in_ready), int'(!pending));
      chk("busy", int'(busy), int'(pending || samples.size() > 0));
      if (just_cleared) begin
        chk("sum_after_clear", int'(out_sum), 0);
        chk("ovf_after_clear", int'(out_overflow), 0);
        just_cleared = 0;
      end
      if (pending && out_valid && exp_q.size() > 0) begin
        chk("out_sum", int'(out_sum), exp_q[0] & 8'hFF);
        chk("out_overflow", int'(out_overflow), (exp_q[0] >> 8) & 1);
      end
    end
    if (rst || clear) begin
      if (rst) mon_en = 1;
      samples.delete();
      exp_q.delete();
      pending = 0;
      just_cleared = 1;
    end else if (mon_en) begin
      if (pending) begin
        if (out_ready) begin
          void'(exp_q.pop_front());
          pending = 0;
          n_results++;
        end
      end else if (in_valid) begin
        samples.push_back(int'(in_data));
        if (samples.size() == N) begin
          int total;
          total = 0;
          foreach (samples[i]) total += samples[i];
          exp_q.push_back(((total >= 256) ? 256 : 0) | (total % 256));
          pending = 1;
          samples.delete();
        end
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit ordy, input bit clr, input bit r);
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic seq4(input int a, input int b, input int c, input int d, input bit ordy);
    cyc(1, a, ordy, 0, 0);
    cyc(1, b, ordy, 0, 0);
    cyc(1, c, ordy, 0, 0);
    cyc(1, d, ordy, 0, 0);
  endtask

  initial begin
    rst = 1; clear = 0; in_valid = 0; in_data = 0; out_ready = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);

    // Basic sum and wrap cases
    seq4(10, 20, 30, 40, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    seq4(200, 100, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    seq4(255, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);

    // Backpressure with junk offered while the result is held
    seq4(10, 20, 30, 40, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'hFF, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    seq4(1, 2, 3, 4, 1);
    cyc(0, 0, 1, 0, 0);

    // Input gaps
    cyc(1, 5, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 6, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 7, 1, 0, 0);
    cyc(1, 8, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Clear mid-operation, sample in the clear cycle dropped
    cyc(1, 50, 1, 0, 0);
    cyc(1, 60, 1, 0, 0);
    cyc(1, 99, 1, 1, 0);
    seq4(1, 2, 3, 4, 1);
    cyc(0, 0, 1, 0, 0);

    // Reset while a result is pending
    seq4(9, 9, 9, 9, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Clear while a result is pending
    seq4(100, 100, 100, 100, 0);
    cyc(1, 3, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 6,
          $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
    end

    // Drain any pending result
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    chk("results_drained", exp_q.size(), 0);
    chk("results_seen_min", int'(n_results >= 8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got t=%0t, expected < 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/sample_accumulator_8bit.md
# sample_accumulator_8bit

Sequential accumulator that sits directly upstream-to-downstream around the 8-bit ripple adder. It accepts a stream of unsigned 8-bit samples over a valid/ready handshake and sums exactly NUM_SAMPLES of them through one `adder_8bit` instance. It then presents the wrapped 8-bit sum and a sticky carry-out flag on a valid/ready output handshake. It is the block that drives `adder_8bit` operands each cycle and consumes its sum/carry.

## Interface
- NUM_SAMPLES, 4: samples per result; legal range 2..255; counter width 8 bits.
- clk  input  1  rising-edge clock; only clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial or pending result.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  8  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  out_sum/out_overflow hold a completed result.
- out_sum  output  8  accumulated sum mod 256.
- out_overflow  output  1  1 if any add in this result produced carry-out of bit 7.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  1 in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE.
- Registers: acc[7:0], ovf, cnt[7:0], state.
- Accept: in_valid && in_ready.
- Datapath: `adder_8bit` with a = acc, b = in_data, carry_in = 0.
  - On accept: acc <= sum, ovf <= ovf | overflow, cnt <= cnt + 1.
  - With no accept, acc/ovf/cnt hold.
- IDLE: acc = 0, ovf = 0, cnt = 0, in_ready = 1.
  - Accept -> ACCUM.
- ACCUM: in_ready = 1.
  - Accept with cnt == NUM_SAMPLES-1 -> DONE.
  - Otherwise stay in ACCUM.
- DONE: in_ready = 0, out_valid = 1; in_data/in_valid ignored.
  - out_ready -> IDLE, zeroing acc/ovf/cnt.
  - Otherwise hold all outputs stable.
- out_sum = acc, out_overflow = ovf. Both are meaningful only while out_valid.
- Priority: rst > clear > normal operation.
  - clear in any state -> IDLE with acc/ovf/cnt = 0.
  - A sample presented in the same cycle as clear is dropped.
- Arithmetic: unsigned wrap mod 256; ovf is sticky for the whole result; no saturation.

## Timing
- Reset values (cycle after rst high): state IDLE, in_ready 1, out_valid 0, out_sum 0x00, out_overflow 0, busy 0.
- in_ready, out_valid and busy decode from registered state only. No combinational path from in_valid or out_ready to any output.
- Throughput: one sample per clk in IDLE/ACCUM.
- Latency: out_valid rises the cycle after the NUM_SAMPLES-th accept.
- Minimum result period: NUM_SAMPLES + 1 cycles. No overlap: the next sample is accepted no earlier than the cycle after the output handshake.
- Gaps in in_valid stall the count; there is no timeout.
- rst or clear asserted while DONE: out_valid is 0 the next cycle and the result is lost.
- The critical path is the 8-stage carry ripple acc -> adder -> acc; no pipelining inside the add.

## Structure
- Shared package `accum_pkg` holds:
  - `state_t` enum {IDLE, ACCUM, DONE};
  - constant DATA_WIDTH = 8;
  - constant CNT_WIDTH = 8.
- One sub-module: `adder_8bit`, instantiated once as the datapath adder; carry_in tied low.
- The FSM and counter are coded in this module; no further hierarchy.

## Test plan
- Basic sum (NUM_SAMPLES=4): in_data 10, 20, 30, 40 on consecutive cycles, out_ready=1 -> out_valid for one cycle, one cycle after the 4th accept, with out_sum=100 (0x64), out_overflow=0; in_ready back to 1 the following cycle.
- Wrap and sticky flag: 200, 100, 0, 0 -> out_sum=44 (0x2C), out_overflow=1. Also 255, 1, 0, 0 -> out_sum=0, out_overflow=1.
- Backpressure: out_ready held 0 for 5 cycles after result 10+20+30+40 while in_valid=1 with in_data=0xFF -> out_valid/out_sum=100 held stable, in_ready=0, no samples absorbed. The next result after out_ready uses only new samples.
- Input gaps: 5, idle, idle, 6, idle, 7, 8 -> out_sum=26, out_overflow=0; busy=1 from the first accept until the handshake.
- Clear mid-operation: accept 50, 60, pulse clear, then 1, 2, 3, 4 -> single result out_sum=10, out_overflow=0. A sample offered in the clear cycle is not counted.
- Reset in DONE: result pending with out_ready=0, assert rst one cycle -> next cycle out_valid=0, out_sum=0, in_ready=1, busy=0.
